// File: rtl/switch_debouncer.sv
// Push-button debouncer: synchroniser chain plus a four-state qualifier.
// Optional RisePulse/FallPulse outputs are built when DEBOUNCE_PULSE_EN is defined.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic Clock,
    input  logic nReset,
    input  logic SwitchIn,
    output logic ReadyIn,
    output logic Busy
`ifdef DEBOUNCE_PULSE_EN
    ,
    output logic RisePulse,
    output logic FallPulse
`endif
);

    localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    // The entry edge into a CHECK state already consumes the first stable
    // sample, so the counter holds (samples seen - 1) and the last one is
    // recognised at DEBOUNCE_CYCLES-2.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        STABLE_HI = 2'b00,
        CHECK_LO  = 2'b01,
        STABLE_LO = 2'b10,
        CHECK_HI  = 2'b11
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_sw;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
`ifdef DEBOUNCE_PULSE_EN
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
`endif

    // Synchroniser chain, idles at the released level
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SwitchIn};
        end
    end

    assign sync_sw = sync_q[SYNC_STAGES-1];

    // State and qualification counter registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: leave a STABLE state on the opposite level, abort a CHECK on any reversal
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_HI: begin
                if (!sync_sw) begin
                    state_d = CHECK_LO;
                    cnt_d   = '0;
                end
            end
            CHECK_LO: begin
                if (sync_sw) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_LO: begin
                if (sync_sw) begin
                    state_d = CHECK_HI;
                    cnt_d   = '0;
                end
            end
            CHECK_HI: begin
                if (!sync_sw) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_HI;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-values: level changes only on a completed qualification
    always_comb begin
        ready_d = ready_q;
        busy_d  = (state_d == CHECK_LO) || (state_d == CHECK_HI);
`ifdef DEBOUNCE_PULSE_EN
        rise_d  = 1'b0;
        fall_d  = 1'b0;
`endif
        case (state_q)
            CHECK_LO: begin
                if (state_d == STABLE_LO) begin
                    ready_d = 1'b0;
`ifdef DEBOUNCE_PULSE_EN
                    fall_d  = 1'b1;
`endif
                end
            end
            CHECK_HI: begin
                if (state_d == STABLE_HI) begin
                    ready_d = 1'b1;
`ifdef DEBOUNCE_PULSE_EN
                    rise_d  = 1'b1;
`endif
                end
            end
            STABLE_HI, STABLE_LO: begin
                ready_d = ready_q;
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

    // Registered outputs so ReadyIn and Busy come straight from flops
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef DEBOUNCE_PULSE_EN
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
`endif
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef DEBOUNCE_PULSE_EN
            rise_q  <= rise_d;
            fall_q  <= fall_d;
`endif
        end
    end

    assign ReadyIn = ready_q;
    assign Busy    = busy_q;
`ifdef DEBOUNCE_PULSE_EN
    assign RisePulse = rise_q;
    assign FallPulse = fall_q;
`endif

endmodule
